spi_frame_sequencer: RTL
========================

Name: spi_frame_sequencer

Overview:
- Single-clock SPI master sequencer for the APB-to-SPI bridge.
- Pops 17-bit command words {wr, addr[7:0], data[7:0]} from the command FIFO and generates SCLK, CS_n and MOSI (SPI mode 0).
- On read commands, captures MISO and pushes the 8-bit result into the response FIFO.
- Sits between the FIFOs and the SPI pins, in the PCLK domain.

Parameters:
- WIDTH, 8: address and data width; the command word is 2*WIDTH+1 bits.
- CLK_DIV, 2: SCLK half-period in PCLK cycles; legal values are 1 to 255.
- CS_SETUP, 1: PCLK cycles of CS_n low before the first SCLK edge; legal values are 1 to 15.
- CS_HOLD, 1: PCLK cycles of CS_n low after the last SCLK fall; legal values are 1 to 15.

Ports:
- PCLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new frames to start.
- cmd_empty  in  1  command FIFO empty. The FIFO is first-word-fall-through: cmd_dout is valid whenever cmd_empty=0.
- cmd_dout  in  2*WIDTH+1  head command. Bit 2W = wr (1 = write, 0 = read); bits [2W-1:W] = addr; bits [W-1:0] = data.
- cmd_rd_en  out  1  one-cycle pop strobe.
- rsp_full  in  1  response FIFO full.
- rsp_wr_en  out  1  one-cycle push strobe.
- rsp_din  out  WIDTH  read data.
- SCLK_o  out  1  SPI clock, idles low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- CS_n  out  1  chip select, active low.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame ends.

Behaviour:
- Reset values: CS_n=1, SCLK_o=0, MOSI=0, cmd_rd_en=0, rsp_wr_en=0, rsp_din=0, busy=0, frame_done=0, state=IDLE.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE, start condition: enable=1, cmd_empty=0, and (wr=1 or rsp_full=0).
  - On the start cycle, cmd_rd_en=1 for exactly one cycle and cmd_dout is latched into the shift register.
  - Next state is SETUP.
  - A read at the FIFO head while rsp_full=1 is not popped; it stalls with no pop and CS_n stays high. The sequencer is the sole response-FIFO writer, so the space checked at start is reserved for the frame.
- SETUP: CS_n=0, SCLK_o=0, MOSI = latched bit 2W. Lasts CS_SETUP cycles.
- SHIFT: N = 2W+1 bits, MSB first.
  - Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
  - MOSI changes only on the PCLK edge where SCLK_o falls (or on SETUP entry for the first bit).
  - MISO is sampled on the PCLK edge where SCLK_o rises.
  - Write frame: all 17 bits come from the command word.
  - Read frame: bits 16..8 are {0, addr}; the last W bits drive MOSI=0, and MISO samples are shifted MSB-first into rsp_din.
  - A bit counter (5 bits) and a divide counter (8 bits) run here. After the high phase of bit N, SCLK_o=0 and the state moves to HOLD.
- HOLD: CS_n=0 for CS_HOLD cycles. On the exit edge:
  - CS_n=1 and frame_done=1.
  - For a read, rsp_wr_en=1 with rsp_din stable.
- GAP: one cycle with CS_n=1, then IDLE. The minimum CS_n-high time between back-to-back frames is 2 cycles (GAP plus the IDLE start cycle).
- Timing:
  - CS_n-low duration = CS_SETUP + N*2*CLK_DIV + CS_HOLD.
  - Pop-to-pop period for back-to-back frames = that duration + 2.
- enable deasserted mid-frame: the current frame completes normally; no new start follows.
- Reset mid-frame: next cycle returns to IDLE with all outputs at reset values. The popped command is discarded, with no rsp push and no frame_done.
- cmd_rd_en and rsp_wr_en are never asserted while reset=1.

Test Plan:
Common setup: WIDTH=8, CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, so CS_n-low duration = 70 cycles.
- Write 17'h1_A5_3C, enable=1:
  - One cmd_rd_en pulse; CS_n low for 70 cycles.
  - MOSI at the 17 SCLK rises = 1,1010_0101,0011_1100.
  - No rsp_wr_en; frame_done once.
- Read 17'h0_42_00 with the slave model driving 8'h9E on MISO:
  - MOSI = 0,0100_0010,0000_0000.
  - rsp_wr_en pulses once with rsp_din=8'h9E, in the same cycle CS_n rises.
- Backpressure:
  - Read at the head and rsp_full=1 for 50 cycles: no pop, CS_n=1, busy=0.
  - Drop rsp_full: pop on the next cycle. Then a write with rsp_full=1 proceeds normally.
- Back-to-back writes 17'h1_01_FF and 17'h1_02_00 queued:
  - Two frames; CS_n high exactly 2 cycles between them.
  - Pop strobes 72 cycles apart.
- Reset at cycle 20 of a read frame:
  - Next cycle CS_n=1, SCLK_o=0, busy=0; no rsp_wr_en.
  - After release, the next FIFO entry starts a clean frame.
- enable dropped at cycle 10 of a write frame with 3 commands queued:
  - The current frame finishes; no further pops while enable=0.
  - Re-enable: the remaining 2 frames run.

Source files
------------

// File: rtl/spi_frame_sequencer.sv
// SPI mode-0 master: pops {wr, addr, data} commands, shifts them out MSB first, and pushes read data.
// Frame: CS_n low for CS_SETUP + (2W+1)*2*CLK_DIV + CS_HOLD cycles; pop-to-pop period is that plus 2.
// A read is held in the FIFO until the response FIFO has room; a write never waits on rsp_full.
module spi_frame_sequencer #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic               PCLK,
  input  logic               reset,
  input  logic               enable,
  input  logic               cmd_empty,
  input  logic [2*WIDTH:0]   cmd_dout,
  output logic               cmd_rd_en,
  input  logic               rsp_full,
  output logic               rsp_wr_en,
  output logic [WIDTH-1:0]   rsp_din,
  output logic               SCLK_o,
  output logic               MOSI,
  input  logic               MISO,
  output logic               CS_n,
  output logic               busy,
  output logic               frame_done
);
  localparam int N  = 2*WIDTH + 1;
  localparam int BW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [7:0]       div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             is_rd_q, is_rd_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             push_q, push_d;
  logic             start;

  // A read only starts when its response slot is guaranteed.
  assign start = (state_q == IDLE) && enable && !cmd_empty && (cmd_dout[N-1] || !rsp_full);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    push_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          is_rd_d = ~cmd_dout[N-1];
          shreg_d = cmd_dout[N-1] ? cmd_dout : {1'b0, cmd_dout[N-2:WIDTH], {WIDTH{1'b0}}};
          mosi_d  = cmd_dout[N-1];
          cs_n_d  = 1'b0;
          cnt_d   = 4'(CS_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = SHIFT;
          div_d   = 8'd0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SHIFT: begin
        if (div_q == 8'(CLK_DIV - 1)) begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (is_rd_q) rx_d = {rx_q[WIDTH-2:0], MISO};
          end else begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[N-2:0], 1'b0};
            if (bit_q == BW'(N - 1)) begin
              state_d = HOLD;
              cnt_d   = 4'(CS_HOLD - 1);
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_q + 1'b1;
              mosi_d = shreg_q[N-2];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          push_d  = is_rd_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rx_q    <= '0;
      div_q   <= 8'd0;
      bit_q   <= '0;
      cnt_q   <= 4'd0;
      is_rd_q <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      push_q  <= push_d;
    end
  end

  // Strobes are masked by reset so a pop or push never lands while the block is being cleared.
  assign cmd_rd_en  = start & ~reset;
  assign rsp_wr_en  = push_q & ~reset;
  assign rsp_din    = rx_q;
  assign SCLK_o     = sclk_q;
  assign MOSI       = mosi_q;
  assign CS_n       = cs_n_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
